exe_stage_alu: RTL and testbench

- EXE-stage datapath that consumes the shifted/immediate second operand (val2) produced by the operand-2 generator and the first operand (val_rn) from the ID/EXE register.
- Performs the ARM data-processing operation selected by exe_cmd and maintains the NZCV status register.
- Registers the result and control bits into the EXE/MEM pipeline register.
- Outputs feed the MEM stage; status_q feeds the ID-stage condition checker.

---
 rtl/exe_stage_alu_if.sv | 40 ++++
 rtl/exe_stage_alu.sv | 129 ++++++++++++
 tb/tb_exe_stage_alu.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_alu_if.sv
// EXE-stage bus: ID/EXE operands and control in, EXE/MEM register and NZCV out.
interface exe_stage_alu_if #(
    parameter int WIDTH = 32
);
    logic             freeze;
    logic             flush;
    logic             valid_in;
    logic [3:0]       exe_cmd;
    logic             s_in;
    logic             wb_en_in;
    logic             mem_r_en_in;
    logic             mem_w_en_in;
    logic [3:0]       dest_in;
    logic [WIDTH-1:0] val_rn;
    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] val_rm;

    logic [WIDTH-1:0] alu_res_q;
    logic [WIDTH-1:0] store_data_q;
    logic [3:0]       dest_q;
    logic             wb_en_q;
    logic             mem_r_en_q;
    logic             mem_w_en_q;
    logic             valid_q;
    logic [3:0]       status_q;

    modport master (
        output freeze, flush, valid_in, exe_cmd, s_in, wb_en_in, mem_r_en_in,
               mem_w_en_in, dest_in, val_rn, val2, val_rm,
        input  alu_res_q, store_data_q, dest_q, wb_en_q, mem_r_en_q,
               mem_w_en_q, valid_q, status_q
    );

    modport slave (
        input  freeze, flush, valid_in, exe_cmd, s_in, wb_en_in, mem_r_en_in,
               mem_w_en_in, dest_in, val_rn, val2, val_rm,
        output alu_res_q, store_data_q, dest_q, wb_en_q, mem_r_en_q,
               mem_w_en_q, valid_q, status_q
    );
endinterface

// File: rtl/exe_stage_alu.sv
// ARM data-processing ALU with NZCV status register and EXE/MEM pipeline register.
module exe_stage_alu #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    exe_stage_alu_if.slave       bus
);
    typedef enum logic [3:0] {
        OP_MOV = 4'b0001,
        OP_ADD = 4'b0010,
        OP_ADC = 4'b0011,
        OP_SUB = 4'b0100,
        OP_SBC = 4'b0101,
        OP_AND = 4'b0110,
        OP_ORR = 4'b0111,
        OP_EOR = 4'b1000,
        OP_MVN = 4'b1001
    } alu_op_e;

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] r_alu_res;
    logic [WIDTH-1:0] r_store_data;
    logic [3:0]       r_dest;
    logic             r_wb_en;
    logic             r_mem_r_en;
    logic             r_mem_w_en;
    logic             r_valid;
    logic [3:0]       r_status;

    alu_op_e          w_op;
    logic [WIDTH-1:0] w_op_b;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;

    assign w_op = alu_op_e'(bus.exe_cmd);

    // Subtraction is rn + ~val2 + cin so C comes out as the ARM not-borrow.
    always_comb begin
        w_op_b  = bus.val2;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (w_op)
            OP_ADD: w_arith = 1'b1;
            OP_ADC: begin
                w_arith = 1'b1;
                w_cin   = r_status[1];
            end
            OP_SUB: begin
                w_arith = 1'b1;
                w_op_b  = ~bus.val2;
                w_cin   = 1'b1;
            end
            OP_SBC: begin
                w_arith = 1'b1;
                w_op_b  = ~bus.val2;
                w_cin   = r_status[1];
            end
            default: w_arith = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, bus.val_rn} + {1'b0, w_op_b} + {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_res = '0;
        case (w_op)
            OP_MOV:                         w_res = bus.val2;
            OP_MVN:                         w_res = ~bus.val2;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: w_res = w_sum[WIDTH-1:0];
            OP_AND:                         w_res = bus.val_rn & bus.val2;
            OP_ORR:                         w_res = bus.val_rn | bus.val2;
            OP_EOR:                         w_res = bus.val_rn ^ bus.val2;
            default:                        w_res = '0;
        endcase
    end

    assign w_n = w_res[MSB];
    assign w_z = (w_res == '0);
    assign w_c = w_arith ? w_sum[WIDTH] : r_status[1];
    // Using the effective operand b makes one overflow formula cover add and sub.
    assign w_v = w_arith ? ((bus.val_rn[MSB] == w_op_b[MSB]) && (w_res[MSB] != bus.val_rn[MSB]))
                         : r_status[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alu_res    <= '0;
            r_store_data <= '0;
            r_dest       <= '0;
            r_wb_en      <= 1'b0;
            r_mem_r_en   <= 1'b0;
            r_mem_w_en   <= 1'b0;
            r_valid      <= 1'b0;
            r_status     <= '0;
        end else if (bus.flush) begin
            r_wb_en      <= 1'b0;
            r_mem_r_en   <= 1'b0;
            r_mem_w_en   <= 1'b0;
            r_valid      <= 1'b0;
        end else if (!bus.freeze) begin
            r_alu_res    <= w_res;
            r_store_data <= bus.val_rm;
            r_dest       <= bus.dest_in;
            r_valid      <= bus.valid_in;
            r_wb_en      <= bus.valid_in & bus.wb_en_in;
            r_mem_r_en   <= bus.valid_in & bus.mem_r_en_in;
            r_mem_w_en   <= bus.valid_in & bus.mem_w_en_in;
            if (bus.valid_in && bus.s_in) begin
                r_status <= {w_n, w_z, w_c, w_v};
            end
        end
    end

    assign bus.alu_res_q    = r_alu_res;
    assign bus.store_data_q = r_store_data;
    assign bus.dest_q       = r_dest;
    assign bus.wb_en_q      = r_wb_en;
    assign bus.mem_r_en_q   = r_mem_r_en;
    assign bus.mem_w_en_q   = r_mem_w_en;
    assign bus.valid_q      = r_valid;
    assign bus.status_q     = r_status;
endmodule

// File: tb/tb_exe_stage_alu.sv
// Directed-vector bench for exe_stage_alu with hand-computed results and NZCV.
module tb_exe_stage_alu;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    exe_stage_alu_if #(.WIDTH(32)) bus ();

    exe_stage_alu #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] cmd, input logic s, input logic [31:0] rn,
                         input logic [31:0] v2, input logic [31:0] rm, input logic [3:0] dest,
                         input logic wb, input logic mr, input logic mw, input logic valid,
                         input logic frz, input logic fl);
        bus.exe_cmd     = cmd;
        bus.s_in        = s;
        bus.val_rn      = rn;
        bus.val2        = v2;
        bus.val_rm      = rm;
        bus.dest_in     = dest;
        bus.wb_en_in    = wb;
        bus.mem_r_en_in = mr;
        bus.mem_w_en_in = mw;
        bus.valid_in    = valid;
        bus.freeze      = frz;
        bus.flush       = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(4'b0010, 1'b1, 32'h1234_5678, 32'h0000_0001, 32'hDEAD_BEEF, 4'hF,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'h0) $display("FAIL reset_res got %h want %h", bus.alu_res_q, 32'h0);
        else n_pass++;
        n_total++;
        if (bus.store_data_q !== 32'h0) $display("FAIL reset_store got %h want %h", bus.store_data_q, 32'h0);
        else n_pass++;
        n_total++;
        if ({bus.dest_q, bus.wb_en_q, bus.mem_r_en_q, bus.mem_w_en_q, bus.valid_q} !== 8'h00)
            $display("FAIL reset_ctrl got %b%b%b%b dest %h want 0",
                     bus.wb_en_q, bus.mem_r_en_q, bus.mem_w_en_q, bus.valid_q, bus.dest_q);
        else n_pass++;
        n_total++;
        if (bus.status_q !== 4'b0000) $display("FAIL reset_status got %b want 0000", bus.status_q);
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_adds_overflow();
        drive(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'hA5A5_A5A5, 4'h3,
              1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'h8000_0000) $display("FAIL adds_res got %h want 80000000", bus.alu_res_q);
        else n_pass++;
        n_total++;
        if (bus.status_q !== 4'b1001) $display("FAIL adds_status got %b want 1001", bus.status_q);
        else n_pass++;
        n_total++;
        if (bus.dest_q !== 4'h3 || bus.wb_en_q !== 1'b1 || bus.valid_q !== 1'b1 || bus.store_data_q !== 32'hA5A5_A5A5)
            $display("FAIL adds_ctrl got dest %h wb %b valid %b sd %h want 3 1 1 a5a5a5a5",
                     bus.dest_q, bus.wb_en_q, bus.valid_q, bus.store_data_q);
        else n_pass++;
    endtask

    task automatic test_subs();
        drive(4'b0100, 1'b1, 32'd5, 32'd5, 32'h0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'h0 || bus.status_q !== 4'b0110)
            $display("FAIL subs_zero got res %h nzcv %b want 00000000 0110", bus.alu_res_q, bus.status_q);
        else n_pass++;
        drive(4'b0100, 1'b1, 32'd3, 32'd5, 32'h0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'hFFFF_FFFE || bus.status_q !== 4'b1000)
            $display("FAIL subs_borrow got res %h nzcv %b want fffffffe 1000", bus.alu_res_q, bus.status_q);
        else n_pass++;
    endtask

    task automatic test_adc_chain();
        drive(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'h0 || bus.status_q !== 4'b0110)
            $display("FAIL adc_setup got res %h nzcv %b want 00000000 0110", bus.alu_res_q, bus.status_q);
        else n_pass++;
        drive(4'b0011, 1'b0, 32'h0, 32'h0, 32'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'h1 || bus.status_q !== 4'b0110)
            $display("FAIL adc_carry got res %h nzcv %b want 00000001 0110", bus.alu_res_q, bus.status_q);
        else n_pass++;
    endtask

    task automatic test_logical();
        // 0x80000000 - 1 overflows with no borrow: NZCV 0011.
        drive(4'b0100, 1'b1, 32'h8000_0000, 32'h1, 32'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'h7FFF_FFFF || bus.status_q !== 4'b0011)
            $display("FAIL subs_ovf got res %h nzcv %b want 7fffffff 0011", bus.alu_res_q, bus.status_q);
        else n_pass++;
        drive(4'b0110, 1'b1, 32'hF0, 32'h0F, 32'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'h0 || bus.status_q !== 4'b0111)
            $display("FAIL ands_keep_cv got res %h nzcv %b want 00000000 0111", bus.alu_res_q, bus.status_q);
        else n_pass++;
        drive(4'b1001, 1'b0, 32'h0, 32'h0, 32'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'hFFFF_FFFF || bus.status_q !== 4'b0111)
            $display("FAIL mvn got res %h nzcv %b want ffffffff 0111", bus.alu_res_q, bus.status_q);
        else n_pass++;
        drive(4'b0111, 1'b0, 32'hF0, 32'h0F, 32'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'hFF) $display("FAIL orr got %h want 000000ff", bus.alu_res_q);
        else n_pass++;
        drive(4'b1000, 1'b0, 32'hFF, 32'h0F, 32'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'hF0) $display("FAIL eor got %h want 000000f0", bus.alu_res_q);
        else n_pass++;
        drive(4'b0001, 1'b1, 32'h0, 32'h8000_0001, 32'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'h8000_0001 || bus.status_q !== 4'b1011)
            $display("FAIL movs got res %h nzcv %b want 80000001 1011", bus.alu_res_q, bus.status_q);
        else n_pass++;
        drive(4'b0101, 1'b1, 32'd10, 32'd3, 32'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'd7 || bus.status_q !== 4'b0010)
            $display("FAIL sbcs got res %h nzcv %b want 00000007 0010", bus.alu_res_q, bus.status_q);
        else n_pass++;
        drive(4'b1111, 1'b1, 32'h1234, 32'h5678, 32'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'h0 || bus.status_q !== 4'b0110)
            $display("FAIL undef_op got res %h nzcv %b want 00000000 0110", bus.alu_res_q, bus.status_q);
        else n_pass++;
    endtask

    task automatic test_freeze_flush();
        drive(4'b0010, 1'b1, 32'd1, 32'd2, 32'h55, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'd3 || bus.status_q !== 4'b0000)
            $display("FAIL ff_setup got res %h nzcv %b want 00000003 0000", bus.alu_res_q, bus.status_q);
        else n_pass++;
        drive(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h99, 4'h9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'd3 || bus.status_q !== 4'b0000 || bus.dest_q !== 4'h5 ||
            bus.store_data_q !== 32'h55 || bus.wb_en_q !== 1'b1 || bus.mem_r_en_q !== 1'b0)
            $display("FAIL freeze_hold got res %h nzcv %b dest %h sd %h wb %b mr %b want 3 0000 5 55 1 0",
                     bus.alu_res_q, bus.status_q, bus.dest_q, bus.store_data_q, bus.wb_en_q, bus.mem_r_en_q);
        else n_pass++;
        drive(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h99, 4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        n_total++;
        if ({bus.wb_en_q, bus.mem_r_en_q, bus.mem_w_en_q, bus.valid_q} !== 4'b0000 || bus.status_q !== 4'b0000)
            $display("FAIL flush got ctrl %b%b%b%b nzcv %b want 0000 0000",
                     bus.wb_en_q, bus.mem_r_en_q, bus.mem_w_en_q, bus.valid_q, bus.status_q);
        else n_pass++;
        drive(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h77, 4'h6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_total++;
        if ({bus.wb_en_q, bus.mem_r_en_q, bus.mem_w_en_q, bus.valid_q} !== 4'b0000 || bus.status_q !== 4'b0000)
            $display("FAIL bubble got ctrl %b%b%b%b nzcv %b want 0000 0000",
                     bus.wb_en_q, bus.mem_r_en_q, bus.mem_w_en_q, bus.valid_q, bus.status_q);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        drive(4'b0011, 1'b1, 32'h0, 32'h0, 32'h0, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'h1 || bus.status_q !== 4'b0000)
            $display("FAIL b2b_adcs got res %h nzcv %b want 00000001 0000", bus.alu_res_q, bus.status_q);
        else n_pass++;
        // STR: address from ADD, store data and mem_w_en registered.
        drive(4'b0010, 1'b0, 32'h1000, 32'h8, 32'hCAFE_F00D, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        n_total++;
        if (bus.alu_res_q !== 32'h1008 || bus.store_data_q !== 32'hCAFE_F00D || bus.mem_w_en_q !== 1'b1 ||
            bus.wb_en_q !== 1'b0 || bus.status_q !== 4'b0000)
            $display("FAIL str got res %h sd %h mw %b wb %b nzcv %b want 00001008 cafef00d 1 0 0000",
                     bus.alu_res_q, bus.store_data_q, bus.mem_w_en_q, bus.wb_en_q, bus.status_q);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        drive(4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_adds_overflow();
        test_subs();
        test_adc_chain();
        test_logical();
        test_freeze_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
